// File: rtl/hpp_video_pkg.sv
// Shared video timing constants and VRAM types for the scanline fetch path.
package hpp_video_pkg;

  localparam int unsigned H_VISIBLE    = 640;
  localparam int unsigned V_VISIBLE    = 480;
  localparam int unsigned H_TOTAL      = 800;
  localparam int unsigned LINES_TOTAL  = 525;
  localparam int unsigned PIX_PER_WORD = 2;
  localparam int unsigned ADDR_W       = 17;
  localparam int unsigned DATA_W       = 16;
  localparam int unsigned WPL          = H_VISIBLE / PIX_PER_WORD;
  localparam int unsigned LINE_W       = 10;
  localparam int unsigned WORD_W       = 9;
  localparam int unsigned LB_ADDR_W    = WORD_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetch_state_t;

  typedef logic [ADDR_W-1:0] vram_addr_t;
  typedef logic [DATA_W-1:0] vram_data_t;

  // One VRAM port command as driven onto the memory interface.
  typedef struct packed {
    logic       req;
    logic       we;
    vram_addr_t addr;
    vram_data_t wdata;
  } vram_cmd_t;

endpackage

// File: rtl/scanline_fetch_ctrl.sv
// Scanline fetch controller: fills the ping-pong line buffer one line ahead
// of the display and arbitrates VRAM between fetch (priority) and host writes.
// Optional macro HPP_VBLANK_IRQ_EN enables the vblank interrupt.
module scanline_fetch_ctrl
  import hpp_video_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [LINE_W-1:0]    vga_line,
  input  logic [LINE_W-1:0]    vga_pixel,
  input  vram_addr_t           fb_base,
  input  logic                 host_valid,
  output logic                 host_ready,
  input  vram_addr_t           host_addr,
  input  vram_data_t           host_wdata,
  output logic                 vram_req,
  output logic                 vram_we,
  output vram_addr_t           vram_addr,
  output vram_data_t           vram_wdata,
  input  vram_data_t           vram_rdata,
  output logic                 lb_we,
  output logic [LB_ADDR_W-1:0] lb_addr,
  output vram_data_t           lb_wdata,
  output logic                 underrun,
  output logic                 vblank_irq,
  input  logic                 irq_ack
);

  fetch_state_t          r_state,    w_state_nxt;
  logic [WORD_W-1:0]     r_word,     w_word_nxt;
  vram_addr_t            r_line_ptr, w_line_ptr_nxt;
  logic                  r_bank,     w_bank_nxt;
  logic                  r_lb_we,    w_lb_we_nxt;
  logic [LB_ADDR_W-1:0]  r_lb_addr,  w_lb_addr_nxt;
  logic                  r_underrun, w_underrun_nxt;

  logic                  w_trig;
  logic                  w_fetch_ok;
  logic [LINE_W-1:0]     w_tgt;
  logic                  w_issue;
  logic                  w_host_go;
  vram_cmd_t             w_cmd;

  // Line start detection and target line (wraps from the last line to 0).
  assign w_trig     = (vga_pixel == '0) && (vga_line < LINE_W'(LINES_TOTAL));
  assign w_tgt      = (vga_line == LINE_W'(LINES_TOTAL - 1)) ? '0 : vga_line + LINE_W'(1);
  assign w_fetch_ok = w_trig && (w_tgt < LINE_W'(V_VISIBLE));
  // A trigger cycle never issues a read: the running fetch is abandoned.
  assign w_issue    = (r_state == FETCH) && !w_trig;

  // State, pointer and line-buffer write registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_word     <= '0;
      r_line_ptr <= '0;
      r_bank     <= 1'b0;
      r_lb_we    <= 1'b0;
      r_lb_addr  <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_word     <= w_word_nxt;
      r_line_ptr <= w_line_ptr_nxt;
      r_bank     <= w_bank_nxt;
      r_lb_we    <= w_lb_we_nxt;
      r_lb_addr  <= w_lb_addr_nxt;
      r_underrun <= w_underrun_nxt;
    end
  end

  // Next-state: a trigger always restarts scheduling; otherwise walk the line.
  always_comb begin
    w_state_nxt    = r_state;
    w_word_nxt     = r_word;
    w_line_ptr_nxt = r_line_ptr;
    w_bank_nxt     = r_bank;
    w_lb_we_nxt    = 1'b0;
    w_lb_addr_nxt  = r_lb_addr;
    w_underrun_nxt = r_underrun;
    if (w_trig) begin
      if (r_state != IDLE) begin
        w_underrun_nxt = 1'b1;
      end
      w_state_nxt = IDLE;
      if (w_fetch_ok) begin
        w_state_nxt    = FETCH;
        w_word_nxt     = '0;
        w_bank_nxt     = w_tgt[0];
        w_line_ptr_nxt = (w_tgt == '0) ? fb_base : r_line_ptr + ADDR_W'(WPL);
      end
    end else begin
      case (r_state)
        FETCH: begin
          w_lb_we_nxt   = 1'b1;
          w_lb_addr_nxt = {r_bank, r_word};
          if (r_word == WORD_W'(WPL - 1)) begin
            w_state_nxt = DRAIN;
          end else begin
            w_word_nxt = r_word + WORD_W'(1);
          end
        end
        DRAIN:   w_state_nxt = IDLE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // VRAM port mux: fetch owns the port for the whole FETCH state.
  always_comb begin
    host_ready  = (r_state != FETCH);
    w_host_go   = host_valid && host_ready;
    w_cmd.req   = w_issue || w_host_go;
    w_cmd.we    = w_host_go;
    w_cmd.addr  = w_issue ? r_line_ptr + ADDR_W'(r_word) : host_addr;
    w_cmd.wdata = host_wdata;
  end

  assign vram_req   = w_cmd.req;
  assign vram_we    = w_cmd.we;
  assign vram_addr  = w_cmd.addr;
  assign vram_wdata = w_cmd.wdata;

  // Read data arrives the cycle after issue, aligned with the registered strobe.
  assign lb_we    = r_lb_we;
  assign lb_addr  = r_lb_addr;
  assign lb_wdata = vram_rdata;
  assign underrun = r_underrun;

`ifdef HPP_VBLANK_IRQ_EN
  logic r_vblank_irq;

  // Vblank interrupt: set at first blank line start, set beats ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vblank_irq <= 1'b0;
    end else if ((vga_line == LINE_W'(V_VISIBLE)) && (vga_pixel == '0)) begin
      r_vblank_irq <= 1'b1;
    end else if (irq_ack) begin
      r_vblank_irq <= 1'b0;
    end
  end

  assign vblank_irq = r_vblank_irq;
`else
  logic w_unused_irq_ack;
  assign w_unused_irq_ack = irq_ack;
  assign vblank_irq       = 1'b0;
`endif

endmodule

// File: tb/tb_scanline_fetch_ctrl.sv
// Randomized bench for scanline_fetch_ctrl against a fetch-job reference model.
module tb_scanline_fetch_ctrl;
  import hpp_video_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [LINE_W-1:0]    vga_line;
  logic [LINE_W-1:0]    vga_pixel;
  vram_addr_t           fb_base;
  logic                 host_valid;
  logic                 host_ready;
  vram_addr_t           host_addr;
  vram_data_t           host_wdata;
  logic                 vram_req;
  logic                 vram_we;
  vram_addr_t           vram_addr;
  vram_data_t           vram_wdata;
  vram_data_t           vram_rdata;
  logic                 lb_we;
  logic [LB_ADDR_W-1:0] lb_addr;
  vram_data_t           lb_wdata;
  logic                 underrun;
  logic                 vblank_irq;
  logic                 irq_ack;

  always #5 clk = ~clk;

  scanline_fetch_ctrl u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .vga_line   (vga_line),
    .vga_pixel  (vga_pixel),
    .fb_base    (fb_base),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .vram_req   (vram_req),
    .vram_we    (vram_we),
    .vram_addr  (vram_addr),
    .vram_wdata (vram_wdata),
    .vram_rdata (vram_rdata),
    .lb_we      (lb_we),
    .lb_addr    (lb_addr),
    .lb_wdata   (lb_wdata),
    .underrun   (underrun),
    .vblank_irq (vblank_irq),
    .irq_ack    (irq_ack)
  );

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;

  // Reference model: at most one outstanding line-fetch job.
  bit          m_job, m_drain, m_underrun, m_irq, m_bank, m_pend;
  int          m_word;
  logic [16:0] m_ptr, m_base;
  logic [9:0]  m_pend_addr;
  logic [15:0] m_pend_data;
  bit          d_rd;
  logic [16:0] d_rd_addr;
  int          lb_cnt;

  int seq1[$] = '{523, 524, 0, 1, 2, 3, 4, 5, 6, 700, 477, 478, 479, 480, 481, 522, 523};
  int seq2_len[$] = '{150, 321, 322, 60, 400, 321, 330};

  function automatic logic [15:0] mem_f(input logic [16:0] a);
    return 16'(a ^ (a >> 3)) ^ 16'h5A3C;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_job = 0; m_drain = 0; m_underrun = 0; m_irq = 0; m_bank = 0; m_pend = 0;
    m_word = 0; m_ptr = '0; m_base = '0; d_rd = 0;
  endtask

  function automatic int tgt_of(input int line);
    return (line == LINES_TOTAL - 1) ? 0 : line + 1;
  endfunction

  // One clock of stimulus, comparison and model update.
  task automatic step(input int line, input int pix, input bit hv, input bit inject_reset);
    bit          trig, busy, exp_rd, exp_hr, exp_hgo;
    int          tgt;
    logic [16:0] exp_addr;
    @(negedge clk);
    vga_line   = 10'(line);
    vga_pixel  = 10'(pix);
    host_valid = hv;
    host_addr  = 17'($urandom);
    host_wdata = 16'($urandom);
    irq_ack    = ($urandom_range(0, 39) == 0);
    #1;
    if (inject_reset) begin
      #1 reset_n = 1'b0;
      #1;
      model_reset();
      check_eq("rst_async_lb_we", 32'(lb_we), 32'(0));
      check_eq("rst_async_vram_req", 32'(vram_req), 32'(0));
      check_eq("rst_async_underrun", 32'(underrun), 32'(0));
      check_eq("rst_async_irq", 32'(vblank_irq), 32'(0));
      check_eq("rst_async_host_ready", 32'(host_ready), 32'(1));
      @(posedge clk);
      #1;
      check_eq("rst_hold_lb_we", 32'(lb_we), 32'(0));
      vram_rdata = 16'($urandom);
      @(negedge clk);
      reset_n = 1'b1;
      return;
    end
    trig    = (pix == 0) && (line < LINES_TOTAL);
    tgt     = tgt_of(line);
    busy    = m_job || m_drain;
    exp_rd  = m_job && !trig;
    exp_hr  = !m_job;
    exp_hgo = hv && exp_hr;
    exp_addr = exp_rd ? 17'(m_base + 17'(m_word)) : host_addr;

    check_eq("host_ready", 32'(host_ready), 32'(exp_hr));
    check_eq("vram_req", 32'(vram_req), 32'(exp_rd || exp_hgo));
    check_eq("vram_we", 32'(vram_we), 32'(exp_hgo));
    if (exp_rd || exp_hgo) check_eq("vram_addr", 32'(vram_addr), 32'(exp_addr));
    if (exp_hgo) check_eq("vram_wdata", 32'(vram_wdata), 32'(host_wdata));
    check_eq("lb_we", 32'(lb_we), 32'(m_pend));
    if (m_pend) begin
      check_eq("lb_addr", 32'(lb_addr), 32'(m_pend_addr));
      check_eq("lb_wdata", 32'(lb_wdata), 32'(m_pend_data));
    end
    check_eq("underrun", 32'(underrun), 32'(m_underrun));
    check_eq("vblank_irq", 32'(vblank_irq), 32'(m_irq));

    if (lb_we) lb_cnt++;
    d_rd      = vram_req && !vram_we;
    d_rd_addr = vram_addr;

    m_pend = exp_rd;
    if (exp_rd) begin
      m_pend_addr = {m_bank, 9'(m_word)};
      m_pend_data = mem_f(exp_addr);
    end
    if (trig) begin
      if (busy) m_underrun = 1;
      m_job   = 0;
      m_drain = 0;
      if (tgt < V_VISIBLE) begin
        m_ptr  = (tgt == 0) ? fb_base : 17'(m_ptr + 17'(WPL));
        m_job  = 1;
        m_base = m_ptr;
        m_bank = tgt[0];
        m_word = 0;
      end
    end else begin
      m_drain = 0;
      if (exp_rd) begin
        m_word++;
        if (m_word == WPL) begin
          m_job   = 0;
          m_drain = 1;
        end
      end
    end
`ifdef HPP_VBLANK_IRQ_EN
    if (line == V_VISIBLE && pix == 0) m_irq = 1;
    else if (irq_ack) m_irq = 0;
`endif
    @(posedge clk);
    #1;
    vram_rdata = d_rd ? mem_f(d_rd_addr) : 16'($urandom);
  endtask

  // hv_mode: 0 = random host traffic, 1 = host_valid held high.
  task automatic run_line(input int line, input int len, input int hv_mode);
    for (int p = 0; p < len; p++) begin
      step(line, p, (hv_mode == 1) ? 1'b1 : ($urandom_range(0, 3) == 0), 1'b0);
    end
  endtask

  initial begin
    int n_fetch;
    int tgt;
    int len;
    reset_n    = 1'b0;
    vga_line   = 10'd100;
    vga_pixel  = 10'd5;
    fb_base    = 17'h1000;
    host_valid = 1'b0;
    host_addr  = '0;
    host_wdata = '0;
    vram_rdata = '0;
    irq_ack    = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_vram_req", 32'(vram_req), 32'(0));
    check_eq("reset_vram_we", 32'(vram_we), 32'(0));
    check_eq("reset_lb_we", 32'(lb_we), 32'(0));
    check_eq("reset_underrun", 32'(underrun), 32'(0));
    check_eq("reset_vblank_irq", 32'(vblank_irq), 32'(0));
    @(negedge clk);
    reset_n = 1'b1;

    // Clean frame tail and head: every fetch fits inside its line.
    lb_cnt  = 0;
    n_fetch = 0;
    foreach (seq1[i]) begin
      tgt = tgt_of(seq1[i]);
      if (seq1[i] < LINES_TOTAL && tgt < V_VISIBLE) begin
        n_fetch++;
        len = $urandom_range(330, 420);
      end else begin
        len = $urandom_range(5, 40);
      end
      run_line(seq1[i], len, (seq1[i] == 5) ? 1 : 0);
    end
    check_eq("lb_count", 32'(lb_cnt), 32'(n_fetch * WPL));
    check_eq("underrun_clean", 32'(underrun), 32'(0));

    // New frame with a base near the top of VRAM so addresses wrap.
    fb_base = 17'h1FF80;
    run_line(524, 400, 0);
    run_line(0, 400, 0);
    run_line(1, 20, 0);
    fb_base = 17'($urandom);
    run_line(524, 400, 0);
    run_line(0, 20, 0);

    // Mid-fetch reset at word 50, then recovery from a zero pointer.
    run_line(10, 51, 0);
    step(10, 51, 1'b0, 1'b1);
    for (int p = 53; p < 400; p++) step(10, p, 1'b0, 1'b0);
    run_line(11, 400, 0);
    run_line(12, 30, 0);

    // Deadline misses: short lines, a trigger in DRAIN, abort into blanking.
    foreach (seq2_len[i]) run_line(100 + i, seq2_len[i], 0);
    run_line(477, 400, 0);
    run_line(478, 100, 0);
    run_line(479, 30, 0);
    check_eq("underrun_sticky", 32'(underrun), 32'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
